dnn_argmax_fix6: RTL and testbench
==================================

DNN_ARGMAX_FIX6 -- requirements
Module: dnn_argmax_fix6

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 6, width of each signed class score.
REQ-002 SHALL have parameter NUM_CLASSES, default 10, number of class scores scanned.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of statistics counters.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  scores-ready flag, driven by the upstream sigmoid stage's done.
REQ-007 SHALL have port in_data  input  signed [DATA_WIDTH-1:0] x NUM_CLASSES  class scores, the upstream out array.
REQ-008 SHALL have port label  input  4  expected digit for the current image, sampled with in_data.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port class_idx  output  4  index of maximum score.
REQ-013 SHALL have port class_val  output  signed [DATA_WIDTH-1:0]  maximum score value.
REQ-014 SHALL have port correct  output  1  class_idx equals captured label, valid with out_valid.
REQ-015 SHALL have port clr_stats  input  1  synchronous clear of statistics counters.
REQ-016 SHALL have port total_cnt  output  CNT_WIDTH  accepted results count.
REQ-017 SHALL have port correct_cnt  output  CNT_WIDTH  accepted results with correct=1.

Function
REQ-018 SHALL implement states IDLE, SCAN, HOLD.
REQ-019 SHALL register in_valid each cycle and detect a capture event as in_valid=1 with previous-cycle in_valid=0; a level-held done SHALL produce exactly one capture.
REQ-020 In IDLE on a capture event SHALL latch all in_data and label, set best=in_data[0], best_idx=0, scan index=1, and enter SCAN.
REQ-021 Capture events outside IDLE SHALL be ignored; latched data SHALL be unaffected.
REQ-022 In SCAN, each cycle SHALL compare latched[idx] > best as signed; on strict greater it SHALL update best and best_idx; ties keep the lower index.
REQ-023 SCAN SHALL process one index per cycle; after idx=NUM_CLASSES-1 it SHALL enter HOLD.
REQ-024 Latency: capture at edge N, out_valid SHALL be high after edge N+NUM_CLASSES (edge N+10 by default).
REQ-025 In HOLD, out_valid=1 and class_idx, class_val, correct SHALL be stable until out_ready=1.
REQ-026 Handshake out_valid&out_ready SHALL return to IDLE, drop out_valid next cycle, and retain class_idx/class_val values.
REQ-027 On handshake total_cnt SHALL increment, and correct_cnt SHALL increment if correct=1; both SHALL saturate at all-ones.
REQ-028 clr_stats=1 SHALL zero both counters next edge; when coincident with a handshake, clear SHALL win (counters become 0).
REQ-029 A capture event in the same cycle as the handshake SHALL be ignored (state not IDLE that cycle).

Reset
REQ-030 On rst=0, asynchronously: state IDLE, busy=0, out_valid=0, class_idx=0, class_val=0, correct=0, total_cnt=0, correct_cnt=0, in_valid history=0.
REQ-031 in_valid already high when rst releases SHALL count as a capture event.
REQ-032 Reset during SCAN or HOLD SHALL abandon the result without counting it.

Configuration
REQ-033 Macro DNN_ARGMAX_STATS_EN SHALL gate the statistics feature.
REQ-034 With DNN_ARGMAX_STATS_EN defined: label, correct, clr_stats, total_cnt, correct_cnt behave per REQ-014..017, 027, 028.
REQ-035 Without it: no label register or counters; correct, total_cnt, correct_cnt tied 0; label and clr_stats ignored; argmax timing unchanged.

Verification
REQ-036 Scores {1,-3,5,2,0,-32,7,7,4,-1}, label 6, out_ready=1 -> out_valid at capture+10, class_idx=6, class_val=7, correct=1, total_cnt=1, correct_cnt=1.
REQ-037 All scores -32, label 3 -> class_idx=0, class_val=-32, correct=0, correct_cnt unchanged.
REQ-038 in_valid held high 30 cycles, out_ready=0 for 5 cycles in HOLD -> single capture, outputs stable 5 cycles, one count on accept.
REQ-039 Second in_valid pulse during SCAN with different scores -> ignored; result matches first set.
REQ-040 clr_stats asserted in handshake cycle with total_cnt=5 -> total_cnt=0, correct_cnt=0 next cycle.
REQ-041 rst=0 mid-SCAN, then rst=1 with in_valid low -> IDLE, all outputs 0, no counter change; build without DNN_ARGMAX_STATS_EN -> counters always 0, class_idx as REQ-036.

Source files
------------

// File: rtl/dnn_argmax_fix6.sv
// dnn_argmax_fix6: sequential argmax over NUM_CLASSES signed scores.
// Optional statistics (label check, counters) under DNN_ARGMAX_STATS_EN.
module dnn_argmax_fix6 #(
   parameter int DATA_WIDTH  = 6,
   parameter int NUM_CLASSES = 10,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] in_data [NUM_CLASSES],
   input  logic [3:0]                   label,
   output logic                         busy,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [3:0]                   class_idx,
   output logic signed [DATA_WIDTH-1:0] class_val,
   output logic                         correct,
   input  logic                         clr_stats,
   output logic [CNT_WIDTH-1:0]         total_cnt,
   output logic [CNT_WIDTH-1:0]         correct_cnt
);

   localparam int IW = $clog2(NUM_CLASSES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                      state;
   state_t                      state_nx;
   logic                        vld_q;
   logic                        cap;
   logic                        hs;
   logic                        scan_end;
   logic [IW-1:0]               idx;
   logic signed [DATA_WIDTH-1:0] lat [NUM_CLASSES];
   logic signed [DATA_WIDTH-1:0] best;
   logic [3:0]                  best_idx;

   // idx reaching NUM_CLASSES is the commit cycle that
   // publishes the winner into the output registers
   assign cap      = in_valid & ~vld_q;
   assign hs       = (state == HOLD) & out_ready;
   assign scan_end = (idx == IW'(NUM_CLASSES));

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // next-state decode
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (cap) state_nx = SCAN;
         SCAN: if (scan_end) state_nx = HOLD;
         HOLD: if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // status outputs decoded from state
   always_comb begin
      busy      = (state != IDLE);
      out_valid = (state == HOLD);
   end

   // edge history, capture, serial compare and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q     <= 1'b0;
         idx       <= '0;
         best      <= '0;
         best_idx  <= '0;
         class_idx <= '0;
         class_val <= '0;
         for (int i = 0; i < NUM_CLASSES; i++) begin
            lat[i] <= '0;
         end
      end else begin
         vld_q <= in_valid;
         if (state == IDLE && cap) begin
            lat      <= in_data;
            best     <= in_data[0];
            best_idx <= '0;
            idx      <= IW'(1);
         end else if (state == SCAN) begin
            if (!scan_end) begin
               if (lat[idx] > best) begin
                  best     <= lat[idx];
                  best_idx <= 4'(idx);
               end
               idx <= idx + IW'(1);
            end else begin
               class_idx <= best_idx;
               class_val <= best;
            end
         end
      end
   end

`ifdef DNN_ARGMAX_STATS_EN
   logic [3:0] label_q;
   logic       correct_q;

   assign correct = out_valid & correct_q;

   // label capture and correctness flag at commit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         label_q   <= '0;
         correct_q <= 1'b0;
      end else begin
         if (state == IDLE && cap) begin
            label_q <= label;
         end
         if (state == SCAN && scan_end) begin
            correct_q <= (best_idx == label_q);
         end
      end
   end

   // saturating counters; clear overrides a same-cycle accept
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         total_cnt   <= '0;
         correct_cnt <= '0;
      end else if (clr_stats) begin
         total_cnt   <= '0;
         correct_cnt <= '0;
      end else if (hs) begin
         if (total_cnt != '1) begin
            total_cnt <= total_cnt + 1'b1;
         end
         if (correct && correct_cnt != '1) begin
            correct_cnt <= correct_cnt + 1'b1;
         end
      end
   end
`else
   logic stats_unused;

   assign stats_unused = ^{label, clr_stats, hs};
   assign correct      = 1'b0;
   assign total_cnt    = '0;
   assign correct_cnt  = '0;
`endif

endmodule

// File: tb/tb_dnn_argmax_fix6.sv
// tb_dnn_argmax_fix6: randomized argmax bench with a reference model.
// Expectations follow DNN_ARGMAX_STATS_EN the same way the design does.
module tb_dnn_argmax_fix6;

   localparam int DW = 6;
   localparam int NC = 10;
   localparam int CW = 16;
`ifdef DNN_ARGMAX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 in_valid = 1'b0;
   logic signed [DW-1:0] in_data [NC];
   logic [3:0]           label = '0;
   logic                 busy;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [3:0]           class_idx;
   logic signed [DW-1:0] class_val;
   logic                 correct;
   logic                 clr_stats = 1'b0;
   logic [CW-1:0]        total_cnt;
   logic [CW-1:0]        correct_cnt;

   int total = 0;
   int bad   = 0;
   int m_tot = 0;
   int m_cor = 0;

   always #5 clk = ~clk;

   dnn_argmax_fix6 #(
      .DATA_WIDTH (DW),
      .NUM_CLASSES(NC),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .label      (label),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .class_idx  (class_idx),
      .class_val  (class_val),
      .correct    (correct),
      .clr_stats  (clr_stats),
      .total_cnt  (total_cnt),
      .correct_cnt(correct_cnt)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_max(input int s[NC]);
      int mx = -1000;
      foreach (s[i]) if (s[i] > mx) mx = s[i];
      return mx;
   endfunction

   function automatic int ref_idx(input int s[NC]);
      int mx = ref_max(s);
      for (int i = 0; i < NC; i++) if (s[i] == mx) return i;
      return -1;
   endfunction

   function automatic int sat_inc(input int v);
      return (v < (1 << CW) - 1) ? v + 1 : v;
   endfunction

   task automatic load(input int s[NC]);
      for (int i = 0; i < NC; i++) in_data[i] = 6'(s[i]);
   endtask

   task automatic scramble();
      for (int i = 0; i < NC; i++) in_data[i] = 6'($urandom_range(0, 63));
      label = 4'($urandom_range(0, 15));
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, "_tot"}, int'(total_cnt), STATS ? m_tot : 0);
      chk({tag, "_cc"}, int'(correct_cnt), STATS ? m_cor : 0);
   endtask

   task automatic run_img(input int s[NC], input int lbl, input int hold,
                          input bit rdy_early, input bit keep_valid,
                          input bit pulse2, input bit clr_hs,
                          input bit from_rst);
      int ei, ev, ec, k;
      ei = ref_idx(s);
      ev = ref_max(s);
      ec = (STATS && ei == lbl) ? 1 : 0;
      if (from_rst) begin
         rst = 1'b0;
         #1;
         m_tot = 0;
         m_cor = 0;
         load(s);
         label = 4'(lbl);
         in_valid = 1'b1;
         #1;
         rst = 1'b1;
      end else begin
         in_valid = 1'b0;
         step();
         load(s);
         label = 4'(lbl);
         in_valid = 1'b1;
      end
      out_ready = rdy_early;
      step();
      chk("busy_cap", busy, 1);
      chk("ov_cap", out_valid, 0);
      if (!keep_valid) in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 40) begin
         scramble();
         if (pulse2 && k == 2) in_valid = 1'b1;
         if (pulse2 && k == 3) in_valid = 1'b0;
         step();
         k++;
      end
      chk("latency", k, NC);
      chk("idx", int'(class_idx), ei);
      chk("val", int'(class_val), ev);
      chk("corr", int'(correct), ec);
      chk("busy_hold", busy, 1);
      for (int h = 0; h < hold; h++) begin
         scramble();
         step();
         chk("hold_ov", out_valid, 1);
         chk("hold_idx", int'(class_idx), ei);
         chk("hold_val", int'(class_val), ev);
         chk("hold_corr", int'(correct), ec);
      end
      out_ready = 1'b1;
      clr_stats = clr_hs;
      step();
      out_ready = 1'b0;
      clr_stats = 1'b0;
      if (clr_hs) begin
         m_tot = 0;
         m_cor = 0;
      end else begin
         m_tot = sat_inc(m_tot);
         if (ec == 1) m_cor = sat_inc(m_cor);
      end
      chk("ov_acc", out_valid, 0);
      chk("busy_acc", busy, 0);
      chk("idx_keep", int'(class_idx), ei);
      chk("val_keep", int'(class_val), ev);
      chk_counters("acc");
      if (keep_valid) begin
         for (int h = 0; h < 3; h++) begin
            step();
            chk("no_recap", busy, 0);
         end
      end
   endtask

   task automatic gen(output int s[NC]);
      int mode, v;
      mode = $urandom_range(0, 3);
      v = int'($urandom_range(0, 63)) - 32;
      for (int i = 0; i < NC; i++) begin
         case (mode)
            0: s[i] = int'($urandom_range(0, 63)) - 32;
            1: s[i] = int'($urandom_range(0, 4)) - 2;
            2: s[i] = v;
            default: s[i] = $urandom_range(0, 1) ? 31 : -32;
         endcase
      end
   endtask

   initial begin
      int s[NC];
      int lbl, hold;
      bit re, kv, p2, cl;
      for (int i = 0; i < NC; i++) in_data[i] = '0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_ov", out_valid, 0);
      chk("rst_idx", int'(class_idx), 0);
      chk("rst_val", int'(class_val), 0);
      chk("rst_corr", int'(correct), 0);
      chk_counters("rst");
      rst = 1'b1;
      step();

      s = '{1, -3, 5, 2, 0, -32, 7, 7, 4, -1};
      run_img(s, 6, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      s = '{-32, -32, -32, -32, -32, -32, -32, -32, -32, -32};
      run_img(s, 3, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      s = '{-5, 3, 3, -1, 12, 0, 12, -20, 4, 9};
      run_img(s, 4, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 31};
      run_img(s, 9, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      clr_stats = 1'b1;
      step();
      clr_stats = 1'b0;
      m_tot = 0;
      m_cor = 0;
      chk_counters("clr");

      for (int n = 0; n < 5; n++) begin
         gen(s);
         run_img(s, ref_idx(s), 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk("tot5", int'(total_cnt), STATS ? 5 : 0);
      gen(s);
      run_img(s, ref_idx(s), 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      s = '{2, 9, -4, 1, 1, 0, 5, 3, -9, 8};
      run_img(s, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      step();
      gen(s);
      load(s);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      rst = 1'b0;
      #1;
      m_tot = 0;
      m_cor = 0;
      chk("mid_busy", busy, 0);
      chk("mid_ov", out_valid, 0);
      chk("mid_idx", int'(class_idx), 0);
      chk("mid_val", int'(class_val), 0);
      chk_counters("mid");
      step();
      step();
      rst = 1'b1;
      for (int h = 0; h < 12; h++) begin
         step();
         chk("post_busy", busy, 0);
      end
      chk("post_ov", out_valid, 0);
      chk_counters("post");

      s = '{-7, -2, -9, -2, -30, -1, -1, -8, -3, -4};
      run_img(s, 5, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      for (int n = 0; n < 30; n++) begin
         gen(s);
         lbl = $urandom_range(0, 1) ? ref_idx(s) : int'($urandom_range(0, 15));
         re = 1'($urandom_range(0, 1));
         hold = re ? 0 : int'($urandom_range(0, 3));
         kv = 1'($urandom_range(0, 1));
         p2 = kv ? 1'b0 : 1'($urandom_range(0, 1));
         cl = ($urandom_range(0, 7) == 0);
         run_img(s, lbl, hold, re, kv, p2, cl, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
